fft_bin_serializer: RTL and testbench
=====================================

# fft_bin_serializer

Downstream of the final butterfly layer of the 16-point FFT. Captures one complete 16-bin frame per handshake, in the bit-reversed order the final layer produces. Replays the bins one per cycle in natural frequency order over a valid/ready stream to the analysis logic. A two-bank ping-pong buffer lets the next frame load while the current one drains.

## Interface
- DW, 32, width of each real/imag component (signed, Q16.16)
- N, 16, points per frame (fixed; only 16 supported)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  frame present on in_re/in_im
- in_ready  out  1  a bank is free; frame accepted when in_valid && in_ready
- in_re  in  N*DW  real parts; slice p = final-layer output position p (y_p)
- in_im  in  N*DW  imag parts, same layout
- out_valid  out  1  bin present
- out_ready  in  1  consumer accepts bin
- out_re, out_im  out  DW each  bin value
- out_idx  out  4  natural frequency index k
- out_last  out  1  high with k = 15
- max_valid  out  1  one-cycle pulse, frame peak ready (macro only)
- max_bin  out  4  index of peak |re|+|im|
- max_mag  out  DW+1  peak |re|+|im| value, unsigned

## Operation
- Banks: two N-entry storage banks, each with a full flag.
  - Write pointer wp and read pointer rp, 1 bit each.
  - Capture: in_valid && in_ready writes the whole frame into bank wp in one cycle, sets full[wp], toggles wp.
  - in_ready = !full[wp].
- Drain:
  - When full[rp] is set, the beat counter k (4 bits) walks 0..15.
  - Beat k presents in_re/in_im slice rev(k), where rev(k) = {k[0],k[1],k[2],k[3]}.
  - The counter advances only on out_valid && out_ready.
  - On acceptance of k = 15: clear full[rp], toggle rp, reset k to 0.
- FSM, per drain side: IDLE (no full bank) -> STREAM (full[rp]) -> IDLE, or straight back to STREAM if the other bank is already full. No bubble between frames.
- Outputs are registered from the bank. out_re, out_im, out_idx and out_last are held stable while out_valid && !out_ready.
- Simultaneous capture into bank wp and final-beat release of bank rp in the same cycle is legal. Both take effect.
- Both banks full: in_ready = 0. Upstream must hold its frame.
- Reset mid-frame: all buffered frames are discarded.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, out_last = 0, out_idx = 0, out_re = out_im = 0.
  - max_valid = 0, max_bin = 0, max_mag = 0.
  - wp = rp = 0, full = 00, k = 0.
- Latency: frame captured at edge N gives bin 0 valid after edge N+1.
- Throughput: 16 cycles per frame with out_ready held high. Sustained with back-to-back frames.
- in_ready after a release: in_ready rises the cycle after the final beat of a bank is accepted.

## Configuration
- FFT_MAXBIN_EN defined: track the frame peak.
  - Magnitude per beat: m = |re| + |im|, in DW+1 bits unsigned. abs(-2^(DW-1)) = 2^(DW-1), with no saturation needed.
  - Update rule: the peak updates on strictly greater m, so on ties the lowest k wins.
  - Reporting: the cycle after k = 15 is accepted, max_valid pulses for 1 cycle. max_bin/max_mag are then held until the next pulse.
  - Tracker reset: the tracker resets at the start of each frame.
- FFT_MAXBIN_EN undefined: no tracking logic. max_valid, max_bin and max_mag are tied to 0.

## Structure
- Shared package fft_pkg:
  - FFT_N = 16, FFT_LOG2N = 4, FFT_DW = 32.
  - Function bitrev4.
  - Complex struct typedef {re, im}.
- Sub-module fft_maxbin_tracker holds the magnitude, compare and peak registers. It is instantiated only under FFT_MAXBIN_EN.

## Test plan
- Frame 1: in_re slice p = p<<16, in_im = 0, out_ready = 1.
  - Required: 16 beats, out_idx 0..15.
  - Required: out_re = rev(k)<<16.
  - Required: out_last only on beat 15.
- Back-to-back: three frames offered continuously.
  - Required: in_ready drops after 2 captures.
  - Required: 48 contiguous beats with no gap.
  - Required: frame order preserved.
- Backpressure: out_ready toggles 1010...
  - Required: each bin held stable until accepted.
  - Required: frame completes in 32 cycles, with no loss or duplication.
- Reset: assert rst_n low at beat 7.
  - Required: out_valid = 0 and in_ready = 1 immediately.
  - Required: the next frame streams from k = 0.
- FFT_MAXBIN_EN, peak: bin 5 = (-3.0, 4.0), all others 1.0.
  - Required: max_bin = 5, max_mag = 7<<16.
- FFT_MAXBIN_EN, tie: bins 2 and 9 both equal and largest.
  - Required: max_bin = 2.

Source files
------------

// File: rtl/fft_bin_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared constants, types and helpers for the 16-point FFT
//                output serializer (frame size, component width, complex
//                sample struct, drain FSM states and 4-bit index reversal).
//  Revision    : 1.0  initial release
// ============================================================================
package fft_pkg;

    localparam int FFT_N     = 16;
    localparam int FFT_LOG2N = 4;
    localparam int FFT_DW    = 32;

    // One complex bin, Q16.16 signed components.
    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } fft_cplx_t;

    // Drain side of the ping-pong buffer.
    typedef enum logic [0:0] {
        DRAIN_IDLE   = 1'b0,
        DRAIN_STREAM = 1'b1
    } drain_state_t;

    // The final butterfly layer leaves bin k at position rev(k).
    function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_bin_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fft_bin_serializer_if
//  Description : Bundle of the serializer's frame input stream, bin output
//                stream and peak report.
//                  in_valid/in_ready/in_re/in_im : whole 16-bin frame, slice p
//                                                 is final-layer position p
//                  out_valid/out_ready/out_re/out_im/out_idx/out_last :
//                                                 one bin per beat, natural k
//                  max_valid/max_bin/max_mag      : per-frame peak report
//                Modport slave is the serializer, master is its environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface fft_bin_serializer_if #(
    parameter int DW = fft_pkg::FFT_DW,
    parameter int N  = fft_pkg::FFT_N
);

    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_re;
    logic [N*DW-1:0] in_im;

    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_re;
    logic [DW-1:0]   out_im;
    logic [3:0]      out_idx;
    logic            out_last;

    logic            max_valid;
    logic [3:0]      max_bin;
    logic [DW:0]     max_mag;

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_idx, out_last,
               max_valid, max_bin, max_mag
    );

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_idx, out_last,
               max_valid, max_bin, max_mag
    );

endinterface
`default_nettype wire

// File: rtl/fft_bin_serializer_maxbin_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : fft_maxbin_tracker
//  Description : Tracks the largest |re|+|im| over the accepted beats of a
//                frame and reports it once the last beat is accepted.
//                Only built when FFT_MAXBIN_EN is defined.
//                  clk, rst_n        : clock, async active-low reset
//                  i_beat_fire       : a bin was accepted this cycle
//                  i_beat_idx        : its natural index k
//                  i_re, i_im        : its value
//                  o_max_valid       : one-cycle pulse after k = 15 accepted
//                  o_max_bin/o_max_mag : peak index and magnitude, held
//  Revision    : 1.0  initial release
// ============================================================================
`ifdef FFT_MAXBIN_EN
module fft_maxbin_tracker
    import fft_pkg::*;
#(
    parameter int DW = FFT_DW
) (
    input  wire          clk,
    input  wire          rst_n,
    input  wire          i_beat_fire,
    input  wire  [3:0]   i_beat_idx,
    input  wire  [DW-1:0] i_re,
    input  wire  [DW-1:0] i_im,
    output logic         o_max_valid,
    output logic [3:0]   o_max_bin,
    output logic [DW:0]  o_max_mag
);

    localparam logic [DW:0] c_one = {{DW{1'b0}}, 1'b1};

    // One extra bit so that abs(-2^(DW-1)) and the sum of two such values fit.
    function automatic logic [DW:0] abs_ext(input logic [DW-1:0] v);
        logic [DW:0] ext;
        ext = {v[DW-1], v};
        return ext[DW] ? (~ext + c_one) : ext;
    endfunction

    logic [DW:0] r_peak_mag;
    logic [3:0]  r_peak_bin;
    logic        r_max_valid;
    logic [3:0]  r_max_bin;
    logic [DW:0] r_max_mag;

    logic [DW:0] w_mag;
    logic        w_take;
    logic [DW:0] w_peak_mag_nxt;
    logic [3:0]  w_peak_bin_nxt;

    assign w_mag = abs_ext(i_re) + abs_ext(i_im);

    // Beat 0 restarts the search; afterwards only a strictly larger value
    // replaces the peak, so ties keep the lowest index.
    assign w_take         = (i_beat_idx == 4'd0) || (w_mag > r_peak_mag);
    assign w_peak_mag_nxt = w_take ? w_mag      : r_peak_mag;
    assign w_peak_bin_nxt = w_take ? i_beat_idx : r_peak_bin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak_mag  <= '0;
            r_peak_bin  <= '0;
            r_max_valid <= 1'b0;
            r_max_bin   <= '0;
            r_max_mag   <= '0;
        end else begin
            r_max_valid <= 1'b0;
            if (i_beat_fire) begin
                r_peak_mag <= w_peak_mag_nxt;
                r_peak_bin <= w_peak_bin_nxt;
                if (i_beat_idx == 4'hF) begin
                    r_max_valid <= 1'b1;
                    r_max_bin   <= w_peak_bin_nxt;
                    r_max_mag   <= w_peak_mag_nxt;
                end
            end
        end
    end

    assign o_max_valid = r_max_valid;
    assign o_max_bin   = r_max_bin;
    assign o_max_mag   = r_max_mag;

endmodule
`endif
`default_nettype wire

// File: rtl/fft_bin_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_bin_serializer
//  Description : Two-bank ping-pong buffer behind the last FFT butterfly
//                layer. Captures a whole bit-reversed 16-bin frame in one
//                handshake and replays it one bin per cycle in natural order.
//                  clk   : rising-edge clock
//                  rst_n : asynchronous active-low reset, drops all frames
//                  bus   : fft_bin_serializer_if.slave (frame in, bin out,
//                          peak report)
//                Optional: FFT_MAXBIN_EN adds the per-frame peak tracker;
//                without it max_valid/max_bin/max_mag are tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module fft_bin_serializer
    import fft_pkg::*;
(
    input wire clk,
    input wire rst_n,
    fft_bin_serializer_if.slave bus
);

    localparam logic [FFT_LOG2N-1:0] c_last_beat = FFT_LOG2N'(FFT_N - 1);

    fft_cplx_t              r_bank [2][FFT_N];
    logic [1:0]             r_full;
    logic [1:0]             w_full_nxt;
    logic                   r_wp;
    logic                   r_rp;
    drain_state_t           r_state;
    drain_state_t           w_state_nxt;
    logic [FFT_LOG2N-1:0]   r_k;
    logic [FFT_LOG2N-1:0]   w_k_nxt;
    logic                   r_out_valid;
    logic                   w_out_valid_nxt;
    logic                   r_out_last;
    logic signed [FFT_DW-1:0] r_out_re;
    logic signed [FFT_DW-1:0] r_out_im;

    logic                   w_in_ready;
    logic                   w_capture;
    logic                   w_fire;
    logic                   w_release;
    logic                   w_load;
    logic                   w_load_bank;
    fft_cplx_t              w_rd;

    assign w_in_ready = ~r_full[r_wp];
    assign w_capture  = bus.in_valid & w_in_ready;
    assign w_fire     = r_out_valid & bus.out_ready;

    // Frame storage: the whole frame lands in bank wp in a single cycle.
    // Bank wp is never the bank being drained, since capture needs it empty.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int p = 0; p < FFT_N; p++) begin
                r_bank[r_wp][p].re <= bus.in_re[p*FFT_DW +: FFT_DW];
                r_bank[r_wp][p].im <= bus.in_im[p*FFT_DW +: FFT_DW];
            end
        end
    end

    // Drain FSM: r_k is the index of the bin currently in the output register.
    always_comb begin
        w_state_nxt     = r_state;
        w_k_nxt         = r_k;
        w_out_valid_nxt = r_out_valid;
        w_load          = 1'b0;
        w_load_bank     = r_rp;
        w_release       = 1'b0;
        case (r_state)
            DRAIN_IDLE: begin
                if (r_full[r_rp]) begin
                    w_load          = 1'b1;
                    w_k_nxt         = '0;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = DRAIN_STREAM;
                end
            end
            DRAIN_STREAM: begin
                if (w_fire) begin
                    if (r_k != c_last_beat) begin
                        w_load  = 1'b1;
                        w_k_nxt = r_k + 1'b1;
                    end else begin
                        w_release = 1'b1;
                        w_k_nxt   = '0;
                        // Other bank already waiting: start it with no bubble.
                        if (r_full[~r_rp]) begin
                            w_load      = 1'b1;
                            w_load_bank = ~r_rp;
                        end else begin
                            w_out_valid_nxt = 1'b0;
                            w_state_nxt     = DRAIN_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt     = DRAIN_IDLE;
                w_k_nxt         = '0;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    assign w_rd = r_bank[w_load_bank][bitrev4(w_k_nxt)];

    // Capture and release always address different banks, so both may apply.
    always_comb begin
        w_full_nxt = r_full;
        if (w_capture) begin
            w_full_nxt[r_wp] = 1'b1;
        end
        if (w_release) begin
            w_full_nxt[r_rp] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= DRAIN_IDLE;
            r_full      <= 2'b00;
            r_wp        <= 1'b0;
            r_rp        <= 1'b0;
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_full      <= w_full_nxt;
            r_k         <= w_k_nxt;
            r_out_valid <= w_out_valid_nxt;
            if (w_capture) begin
                r_wp <= ~r_wp;
            end
            if (w_release) begin
                r_rp <= ~r_rp;
            end
            if (w_load) begin
                r_out_re   <= w_rd.re;
                r_out_im   <= w_rd.im;
                r_out_last <= (w_k_nxt == c_last_beat);
            end else begin
                r_out_last <= r_out_last & w_out_valid_nxt;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_re    = r_out_re;
    assign bus.out_im    = r_out_im;
    assign bus.out_idx   = r_k;
    assign bus.out_last  = r_out_last;

`ifdef FFT_MAXBIN_EN
    fft_maxbin_tracker #(
        .DW (FFT_DW)
    ) u_maxbin_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_beat_fire (w_fire),
        .i_beat_idx  (r_k),
        .i_re        (r_out_re),
        .i_im        (r_out_im),
        .o_max_valid (bus.max_valid),
        .o_max_bin   (bus.max_bin),
        .o_max_mag   (bus.max_mag)
    );
`else
    assign bus.max_valid = 1'b0;
    assign bus.max_bin   = '0;
    assign bus.max_mag   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_bin_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fft_bin_serializer
//  Description : Self-checking bench for fft_bin_serializer. Captured frames
//                are turned into expected natural-order bins (and the frame
//                peak) by a reference model; a monitor pops and compares on
//                every accepted output beat.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fft_bin_serializer;
    import fft_pkg::*;

    localparam int DW = FFT_DW;
    localparam int N  = FFT_N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_bin_serializer_if #(.DW(DW), .N(N)) bus();

    fft_bin_serializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]    idx;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          last;
    } beat_t;

    typedef struct {
        logic [3:0]  bin;
        logic [DW:0] mag;
    } peak_t;

    beat_t exp_q[$];
    peak_t peak_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    rnd_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Bin k of the natural-order spectrum sits at position p where p is k
    // with its four bits read backwards.
    function automatic int rev_pos(input int p);
        int r = 0;
        int v = p;
        for (int b = 0; b < 4; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    function automatic longint mag1(input logic [DW-1:0] x);
        longint v;
        v = longint'($signed(x));
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_frame(input logic [N*DW-1:0] re_v, input logic [N*DW-1:0] im_v);
        logic [DW-1:0] bre [N];
        logic [DW-1:0] bim [N];
        beat_t  b;
        peak_t  pk;
        longint best;
        longint m;
        int     best_k;
        for (int p = 0; p < N; p++) begin
            bre[rev_pos(p)] = re_v[p*DW +: DW];
            bim[rev_pos(p)] = im_v[p*DW +: DW];
        end
        best = -1;
        best_k = 0;
        for (int k = 0; k < N; k++) begin
            b.idx  = 4'(k);
            b.re   = bre[k];
            b.im   = bim[k];
            b.last = (k == N - 1);
            exp_q.push_back(b);
            m = mag1(bre[k]) + mag1(bim[k]);
            if (m > best) begin
                best   = m;
                best_k = k;
            end
        end
        pk.bin = 4'(best_k);
        pk.mag = (DW+1)'(best);
`ifdef FFT_MAXBIN_EN
        peak_q.push_back(pk);
`endif
    endtask

    // Scoreboard push: a frame is captured at the next edge.
    always @(negedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) begin
            model_frame(bus.in_re, bus.in_im);
        end
    end

    // Monitor: compare accepted beats, hold stability and peak reports.
    logic  held_v = 1'b0;
    beat_t held;
    always @(negedge clk) begin
        beat_t e;
        peak_t pk;
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                checks++;
                if (!bus.out_valid || bus.out_idx !== held.idx || bus.out_re !== held.re ||
                    bus.out_im !== held.im || bus.out_last !== held.last) begin
                    failures++;
                    $display("FAIL hold: got v=%0b k=%0d re=%0h im=%0h required v=1 k=%0d re=%0h im=%0h",
                             bus.out_valid, bus.out_idx, bus.out_re, bus.out_im, held.idx, held.re, held.im);
                end
            end
            held_v = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat: got unexpected k=%0d required no beat", bus.out_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_idx !== e.idx || bus.out_re !== e.re || bus.out_im !== e.im ||
                        bus.out_last !== e.last) begin
                        failures++;
                        $display("FAIL beat: got k=%0d re=%0h im=%0h last=%0b required k=%0d re=%0h im=%0h last=%0b",
                                 bus.out_idx, bus.out_re, bus.out_im, bus.out_last, e.idx, e.re, e.im, e.last);
                    end
                end
            end else if (bus.out_valid) begin
                held_v    = 1'b1;
                held.idx  = bus.out_idx;
                held.re   = bus.out_re;
                held.im   = bus.out_im;
                held.last = bus.out_last;
            end
`ifdef FFT_MAXBIN_EN
            if (bus.max_valid) begin
                checks++;
                if (peak_q.size() == 0) begin
                    failures++;
                    $display("FAIL peak: got unexpected max_valid required none");
                end else begin
                    pk = peak_q.pop_front();
                    if (bus.max_bin !== pk.bin || bus.max_mag !== pk.mag) begin
                        failures++;
                        $display("FAIL peak: got bin=%0d mag=%0h required bin=%0d mag=%0h",
                                 bus.max_bin, bus.max_mag, pk.bin, pk.mag);
                    end
                end
            end
`else
            checks++;
            if (bus.max_valid !== 1'b0 || bus.max_bin !== 4'd0 || bus.max_mag !== '0) begin
                failures++;
                $display("FAIL max_tied: got v=%0b bin=%0d mag=%0h required 0",
                         bus.max_valid, bus.max_bin, bus.max_mag);
            end
`endif
        end
    end

    task automatic send_frame(input logic [N*DW-1:0] re_v, input logic [N*DW-1:0] im_v);
        bit acc;
        bus.in_re    = re_v;
        bus.in_im    = im_v;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
        chk("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 1000; t++) begin
            if (exp_q.size() == 0 && !bus.out_valid) return;
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic rand_frame(output logic [N*DW-1:0] re_v, output logic [N*DW-1:0] im_v);
        for (int p = 0; p < N; p++) begin
            case ($urandom_range(0, 5))
                0:       re_v[p*DW +: DW] = 32'h8000_0000;
                1:       re_v[p*DW +: DW] = 32'h7FFF_FFFF;
                default: re_v[p*DW +: DW] = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       im_v[p*DW +: DW] = 32'h8000_0000;
                default: im_v[p*DW +: DW] = $urandom;
            endcase
        end
    endtask

    task automatic frame_from_bins(input logic [DW-1:0] bre [N], input logic [DW-1:0] bim [N],
                                   output logic [N*DW-1:0] re_v, output logic [N*DW-1:0] im_v);
        for (int k = 0; k < N; k++) begin
            re_v[rev_pos(k)*DW +: DW] = bre[k];
            im_v[rev_pos(k)*DW +: DW] = bim[k];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*DW-1:0] fre;
        logic [N*DW-1:0] fim;
        logic [DW-1:0]   bre [N];
        logic [DW-1:0]   bim [N];
        int cnt;
        int gaps;
        bit found;

        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  bus.in_ready,  1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last",  bus.out_last,  0);
        chk("rst_out_idx",   bus.out_idx,   0);
        chk("rst_out_re",    bus.out_re,    0);
        chk("rst_out_im",    bus.out_im,    0);
        chk("rst_max_valid", bus.max_valid, 0);
        chk("rst_max_bin",   bus.max_bin,   0);
        chk("rst_max_mag",   bus.max_mag,   0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Frame 1: ramp, out_ready high; also latency of the first bin.
        bus.out_ready = 1'b1;
        for (int p = 0; p < N; p++) fre[p*DW +: DW] = 32'(p << 16);
        fim = '0;
        send_frame(fre, fim);
        chk("lat_edge_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_bin0_valid", bus.out_valid, 1);
        chk("lat_bin0_idx",   bus.out_idx,   0);
        wait_drain();

        // Back-to-back: three frames, in_ready drops after two captures.
        fork
            begin
                rand_frame(fre, fim);
                send_frame(fre, fim);
                rand_frame(fre, fim);
                send_frame(fre, fim);
                chk("b2b_in_ready_low", bus.in_ready, 0);
                rand_frame(fre, fim);
                send_frame(fre, fim);
            end
            begin
                found = 1'b0;
                for (int t = 0; t < 50; t++) begin
                    @(posedge clk);
                    #1;
                    if (bus.out_valid) begin
                        found = 1'b1;
                        break;
                    end
                end
                chk("b2b_start", found, 1);
                gaps = 0;
                for (int i = 0; i < 48; i++) begin
                    if (!bus.out_valid) gaps++;
                    @(posedge clk);
                    #1;
                end
                chk("b2b_gaps", gaps, 0);
                chk("b2b_end_valid", bus.out_valid, 0);
            end
        join
        wait_drain();

        // Backpressure: out_ready alternates 0,1,... from the first bin.
        bus.out_ready = 1'b0;
        rand_frame(fre, fim);
        send_frame(fre, fim);
        found = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (bus.out_valid) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("bp_start", found, 1);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            bus.out_ready = (i % 2 == 1);
            if (bus.out_valid) cnt++;
            @(posedge clk);
            #1;
        end
        chk("bp_valid_cycles", cnt, 32);
        chk("bp_done", bus.out_valid, 0);
        chk("bp_queue_empty", exp_q.size(), 0);
        bus.out_ready = 1'b1;

        // Randomized frames with random gaps and random out_ready.
        rnd_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 6; f++) begin
                    rand_frame(fre, fim);
                    send_frame(fre, fim);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drain();

        // Reset at beat 7 with a second frame buffered.
        rand_frame(fre, fim);
        send_frame(fre, fim);
        rand_frame(fre, fim);
        send_frame(fre, fim);
        found = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (bus.out_valid && bus.out_idx == 4'd7) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("rst_beat7_reached", found, 1);
        rst_n = 1'b0;
        exp_q.delete();
        peak_q.delete();
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready",  bus.in_ready,  1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_discard_valid", bus.out_valid, 0);
        rand_frame(fre, fim);
        send_frame(fre, fim);
        @(posedge clk);
        #1;
        chk("post_rst_valid", bus.out_valid, 1);
        chk("post_rst_idx",   bus.out_idx,   0);
        wait_drain();

`ifdef FFT_MAXBIN_EN
        // Peak: bin 5 = (-3.0, 4.0), the rest 1.0.
        for (int k = 0; k < N; k++) begin
            bre[k] = 32'h0001_0000;
            bim[k] = 32'h0000_0000;
        end
        bre[5] = 32'hFFFD_0000;
        bim[5] = 32'h0004_0000;
        frame_from_bins(bre, bim, fre, fim);
        send_frame(fre, fim);
        wait_drain();
        @(posedge clk);
        #1;
        chk("peak_bin", bus.max_bin, 5);
        chk("peak_mag", bus.max_mag, 64'h7_0000);

        // Tie: bins 2 and 9 = (2.0, -2.0), the rest (0.5, 0.5).
        for (int k = 0; k < N; k++) begin
            bre[k] = 32'h0000_8000;
            bim[k] = 32'h0000_8000;
        end
        bre[2] = 32'h0002_0000;
        bim[2] = 32'hFFFE_0000;
        bre[9] = 32'h0002_0000;
        bim[9] = 32'hFFFE_0000;
        frame_from_bins(bre, bim, fre, fim);
        send_frame(fre, fim);
        wait_drain();
        @(posedge clk);
        #1;
        chk("tie_bin", bus.max_bin, 2);
        chk("tie_mag", bus.max_mag, 64'h4_0000);
`else
        for (int k = 0; k < N; k++) begin
            bre[k] = 32'(k << 16);
            bim[k] = 32'(-(k << 16));
        end
        frame_from_bins(bre, bim, fre, fim);
        send_frame(fre, fim);
        wait_drain();
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("final_beats_empty", exp_q.size(), 0);
`ifdef FFT_MAXBIN_EN
        chk("final_peaks_empty", peak_q.size(), 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
